// File: rtl/rv32_instr_fetch_pkg.sv
// Shared types for the RV32 instruction fetch stage and its buffer.
package rv32_instr_fetch_pkg;

   typedef logic [31:0] instr_t;

   localparam instr_t NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      instr_t      instr;
      logic [31:0] pc;
      logic        fault;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2,
      HALT    = 2'd3
   } fetch_state_t;

   function automatic fetch_entry_t fault_entry(input logic [31:0] pc);
      fault_entry = '{instr: NOP_INSTR, pc: pc, fault: 1'b1};
   endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Small circular buffer between fetch and decode; flush beats push.
module rv32_fetch_fifo #(
   parameter int  DEPTH   = 2,
   parameter type entry_t = logic [31:0]
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  entry_t                   push_data,
   input  logic                     pop,
   input  logic                     flush,
   output entry_t                   head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   entry_t        mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop && !empty;
   // A full buffer can still take a push when the head leaves this cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!flush && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rv32_instr_fetch.sv
// RV32 fetch stage: PC, one-deep memory request tracking, decode buffer.
module rv32_instr_fetch
   import rv32_instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  instr_t      imem_rsp_data,
   input  logic        imem_rsp_error,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output instr_t      out_instr,
   output logic [31:0] out_pc,
   output logic        out_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t state;
   fetch_state_t state_nx;
   logic [31:0]  pc;
   logic [31:0]  rq_pc;
   fetch_entry_t push_entry;
   fetch_entry_t head;
   logic [CW-1:0] count;
   logic [CW:0]  occ;
   logic         full;
   logic         empty;
   logic         push;
   logic         pop;
   logic         fire;
   logic         aligned;
   logic         busy;
   logic         rsp_take;
   logic         can_issue;

   assign aligned  = pc[1:0] == 2'b00;
   assign busy     = (state == WAIT) || (state == DISCARD);
   assign rsp_take = (state == WAIT) && imem_rsp_valid
                     && !redirect_valid;
   assign pop      = out_valid && out_ready;
   assign fire     = imem_req_valid && imem_req_ready;

   // Occupancy after this cycle's push/pop decides if a new word fits.
   assign occ = {1'b0, count} + (CW+1)'(rsp_take)
                - (CW+1)'(pop);

   assign can_issue = (state == FETCH)
                      || ((state == WAIT) && imem_rsp_valid
                          && !imem_rsp_error);

   assign imem_req_valid = rstn && can_issue && aligned
                           && !redirect_valid
                           && (occ < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc;

   always_comb begin
      push       = 1'b0;
      push_entry = '{instr: imem_rsp_data, pc: rq_pc, fault: 1'b0};
      if (rsp_take) begin
         push = 1'b1;
         if (imem_rsp_error) push_entry = fault_entry(rq_pc);
      end else if ((state == FETCH) && !aligned && !full
                   && !redirect_valid) begin
         push       = 1'b1;
         push_entry = fault_entry(pc);
      end
   end

   always_comb begin
      state_nx = state;
      if (redirect_valid) begin
         state_nx = (busy && !imem_rsp_valid) ? DISCARD : FETCH;
      end else begin
         unique case (state)
            FETCH: begin
               if (fire)                 state_nx = WAIT;
               else if (!aligned && !full) state_nx = HALT;
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  if (imem_rsp_error) state_nx = HALT;
                  else if (fire)      state_nx = WAIT;
                  else                state_nx = FETCH;
               end
            end
            DISCARD: begin
               if (imem_rsp_valid) state_nx = FETCH;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= FETCH;
         pc    <= RESET_PC;
         rq_pc <= RESET_PC;
      end else begin
         state <= state_nx;
         if (redirect_valid) begin
            pc <= redirect_pc;
         end else if (fire) begin
            pc    <= pc + 32'd4;
            rq_pc <= pc;
         end
      end
   end

   rv32_fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign out_valid = !empty && !redirect_valid;
   assign out_instr = empty ? NOP_INSTR : head.instr;
   assign out_pc    = empty ? 32'h0 : head.pc;
   assign out_fault = !empty && head.fault;

endmodule

// File: tb/tb_rv32_instr_fetch.sv
// Bench for rv32_instr_fetch: memory responder, stream model, directed cases.
module tb_rv32_instr_fetch;
   import rv32_instr_fetch_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        imem_rsp_error = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;

   always #5 clk = ~clk;

   rv32_instr_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_error (imem_rsp_error),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_fault      (out_fault)
   );

   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = 0;
   exp_t        q[$];
   logic [31:0] model_pc = 32'h0;
   int          epoch = 0;
   logic        halted = 1'b0;
   logic        mis_pend = 1'b0;
   logic [31:0] mis_pc = 32'h0;
   logic        pend_valid = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_due = 0;
   int          pend_epoch = 0;
   int          lat = 1;
   logic [31:0] err_addr = 32'h1;
   logic        req_hold = 1'b0;

   logic        s_req_valid, s_fire, s_out_valid, s_out_fault;
   logic [31:0] s_req_addr, s_out_pc, s_out_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return a ^ 32'hA5A5_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h expected=%h",
                  name, cyc, got, exp);
      end
   endtask

   // One clock: drive memory side, sample, check against model, advance.
   task automatic step();
      logic rsp_now, take, err_now, had_pend, exp_ov;
      had_pend = pend_valid;
      rsp_now = pend_valid && (cyc >= pend_due);
      imem_rsp_valid = rsp_now;
      imem_rsp_data = rsp_now ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      imem_rsp_error = rsp_now && (pend_addr == err_addr);
      #2;
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_fire      = imem_req_valid && imem_req_ready;
      s_out_valid = out_valid;
      s_out_pc    = out_pc;
      s_out_instr = out_instr;
      s_out_fault = out_fault;
      take = rsp_now && !redirect_valid && (pend_epoch == epoch);
      err_now = take && imem_rsp_error;
      exp_ov = (q.size() != 0) && !redirect_valid;
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid && q.size() != 0) begin
         chk("out_instr", out_instr, q[0].instr);
         chk("out_pc", out_pc, q[0].pc);
         chk("out_fault", 32'(out_fault), 32'(q[0].fault));
      end
      if (req_hold && !redirect_valid)
         chk("req_stable", 32'(imem_req_valid), 32'd1);
      if (imem_req_valid) begin
         chk("req_addr", imem_req_addr, model_pc);
         chk("req_blocked", 32'(halted || err_now || redirect_valid
             || (pend_valid && !rsp_now)), 32'd0);
      end
      req_hold = imem_req_valid && !s_fire && !redirect_valid;
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (rsp_now) pend_valid = 1'b0;
      if (take) begin
         if (imem_rsp_error) begin
            q.push_back('{NOP_INSTR, pend_addr, 1'b1});
            halted = 1'b1;
         end else begin
            q.push_back('{mem_word(pend_addr), pend_addr, 1'b0});
         end
      end
      if (s_fire) begin
         pend_valid = 1'b1;
         pend_addr  = model_pc;
         pend_due   = cyc + lat;
         pend_epoch = epoch;
         model_pc   = model_pc + 32'd4;
      end
      if (mis_pend && !had_pend && !redirect_valid) begin
         q.push_back('{NOP_INSTR, mis_pc, 1'b1});
         mis_pend = 1'b0;
      end
      if (redirect_valid) begin
         q.delete();
         epoch++;
         model_pc = redirect_pc;
         halted   = redirect_pc[1:0] != 2'b00;
         mis_pend = halted;
         mis_pc   = redirect_pc;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic redirect_to(input logic [31:0] a);
      redirect_valid = 1'b1;
      redirect_pc = a;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_fire(input logic [31:0] exp, input string name,
                            input logic check_addr);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_fire && n < 30);
      chk({name, "_fire"}, 32'(s_fire), 32'd1);
      if (check_addr) chk({name, "_addr"}, s_req_addr, exp);
   endtask

   task automatic wait_out(input logic [31:0] pc, input logic [31:0] instr,
                           input logic fault, input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_out_valid && n < 30);
      chk({name, "_valid"}, 32'(s_out_valid), 32'd1);
      chk({name, "_pc"}, s_out_pc, pc);
      chk({name, "_instr"}, s_out_instr, instr);
      chk({name, "_fault"}, 32'(s_out_fault), 32'(fault));
   endtask

   initial begin
      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'h0000_0013);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_fault", 32'(out_fault), 32'd0);
      rstn = 1'b1;

      // Streaming at one word per cycle with 1-cycle memory.
      step();
      chk("t1_c0_fire", 32'(s_fire), 32'd1);
      chk("t1_c0_addr", s_req_addr, 32'h0);
      step();
      chk("t1_c1_fire", 32'(s_fire), 32'd1);
      chk("t1_c1_addr", s_req_addr, 32'h4);
      chk("t1_c1_ov", 32'(s_out_valid), 32'd0);
      step();
      chk("t1_c2_fire", 32'(s_fire), 32'd1);
      chk("t1_c2_addr", s_req_addr, 32'h8);
      chk("t1_c2_ov", 32'(s_out_valid), 32'd1);
      chk("t1_c2_pc", s_out_pc, 32'h0);
      chk("t1_c2_instr", s_out_instr, 32'h0050_0093);

      // Decode stalls: buffer fills to two, fetch stops, head holds.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t2_req_off", 32'(s_req_valid), 32'd0);
         chk("t2_head_pc", s_out_pc, 32'h4);
      end
      out_ready = 1'b1;
      step();
      chk("t2_rel_pc", s_out_pc, 32'h4);
      chk("t2_rel_fire", 32'(s_fire), 32'd1);
      chk("t2_rel_addr", s_req_addr, 32'hC);
      step();
      chk("t2_next_pc", s_out_pc, 32'h8);

      // Redirect with a slow request outstanding.
      lat = 3;
      wait_fire(32'h0, "t3_pre", 1'b0);
      step();
      redirect_to(32'h100);
      chk("t3_redir_ov", 32'(s_out_valid), 32'd0);
      wait_fire(32'h100, "t3", 1'b1);
      wait_out(32'h100, mem_word(32'h100), 1'b0, "t3_out");

      // Redirect in the same cycle as a response.
      lat = 1;
      wait_fire(32'h0, "t4_pre", 1'b0);
      redirect_to(32'h300);
      chk("t4_redir_ov", 32'(s_out_valid), 32'd0);
      wait_fire(32'h300, "t4", 1'b1);
      wait_out(32'h300, mem_word(32'h300), 1'b0, "t4_out");

      // Access fault halts fetch until the next redirect.
      lat = 2;
      err_addr = 32'h20;
      redirect_to(32'h20);
      wait_out(32'h20, 32'h0000_0013, 1'b1, "t5_out");
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t5_halt_req", 32'(s_req_valid), 32'd0);
      end
      err_addr = 32'h1;
      redirect_to(32'h40);
      wait_fire(32'h40, "t5_resume", 1'b1);

      // Misaligned redirect target.
      redirect_to(32'h102);
      wait_out(32'h102, 32'h0000_0013, 1'b1, "t6_out");
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t6_halt_req", 32'(s_req_valid), 32'd0);
      end
      redirect_to(32'h200);
      wait_fire(32'h200, "t6_resume", 1'b1);

      // PC wraps past the top of the address space.
      lat = 1;
      redirect_to(32'hFFFF_FFF8);
      wait_fire(32'hFFFF_FFF8, "t7_a", 1'b1);
      wait_fire(32'hFFFF_FFFC, "t7_b", 1'b1);
      wait_fire(32'h0000_0000, "t7_c", 1'b1);

      // Mixed backpressure, latency and periodic redirects.
      for (int i = 0; i < 300; i++) begin
         out_ready = (i % 3) != 2;
         imem_req_ready = (i % 5) != 4;
         lat = 1 + (i % 3);
         redirect_valid = (i % 47) == 46;
         redirect_pc = 32'h1000 + 32'(i) * 32'd16;
         step();
      end
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (10) step();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
